// File: rtl/spi_latched_regfile.sv
// spi_latched_regfile: SPI-slave command frames {cmd, addr, data} into a small
// 16-bit register memory, committed by an active-low latch strobe, plus a
// registered actuator-side read port.
// Build macro: SPI_ECHO_HEADER_EN -- read responses carry {8'h01, addr} in the
// upper half instead of zeros.
`timescale 1ns/1ps

module spi_latched_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_n,
  input  logic              latch_data_n,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oeb,
  input  logic [7:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L   = 9'(DEPTH);
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // [1] is the synchronized level, [2] the previous level for edge detect
  logic [2:0] ss_q, sclk_q, latch_q;
  logic [1:0] mosi_q;

  logic [31:0]       rx_q, rx_d;
  logic [31:0]       tx_q, tx_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              fv_q, fv_d;
  logic              fv_now;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic ss_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall, latch_fall;

  assign ss_s       = ss_q[1];
  assign mosi_s     = mosi_q[1];
  assign ss_fall    =  ss_q[2]    & ~ss_q[1];
  assign ss_rise    = ~ss_q[2]    &  ss_q[1];
  assign sclk_rise  = ~sclk_q[2]  &  sclk_q[1];
  assign sclk_fall  =  sclk_q[2]  & ~sclk_q[1];
  assign latch_fall =  latch_q[2] & ~latch_q[1];

  // Fields of the held frame
  logic [7:0]  f_cmd, f_addr;
  logic [15:0] f_data, f_word, rd_hdr;
  logic        f_in_range, rd_in_range;
  logic [AW-1:0] f_idx, rd_idx;

  assign f_cmd       = rx_q[31:24];
  assign f_addr      = rx_q[23:16];
  assign f_data      = rx_q[15:0];
  assign f_idx       = f_addr[AW-1:0];
  assign rd_idx      = rd_addr[AW-1:0];
  assign f_in_range  = {1'b0, f_addr}  < DEPTH_L;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign f_word      = f_in_range ? mem_q[f_idx] : 16'h0000;

`ifdef SPI_ECHO_HEADER_EN
  assign rd_hdr = {CMD_READ, f_addr};
`else
  assign rd_hdr = 16'h0000;
`endif

  // Pad outputs: drive only while selected and enabled
  assign miso_oeb = ss_s | enable_n;
  assign miso     = ~miso_oeb & tx_q[31];
  assign rd_data  = rd_data_q;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ss_q    <= 3'b111;
      sclk_q  <= 3'b000;
      latch_q <= 3'b111;
      mosi_q  <= 2'b00;
    end else begin
      ss_q    <= {ss_q[1:0], ss_n};
      sclk_q  <= {sclk_q[1:0], sclk};
      latch_q <= {latch_q[1:0], latch_data_n};
      mosi_q  <= {mosi_q[0], mosi};
    end
  end

  // Frame receive, transmit shift and commit decode
  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    cnt_d  = cnt_q;
    fv_d   = fv_q;
    fv_now = fv_q;
    mem_we = 1'b0;
    if (enable_n) begin
      rx_d   = '0;
      tx_d   = '0;
      cnt_d  = '0;
      fv_d   = 1'b0;
      fv_now = 1'b0;
    end else begin
      if (ss_fall) begin
        cnt_d = '0;
      end else if (sclk_rise && !ss_s) begin
        rx_d = {rx_q[30:0], mosi_s};
        if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
      end
      if (sclk_fall && !ss_s) tx_d = {tx_q[30:0], 1'b0};
      // a frame closing this cycle is visible to a same-cycle commit
      if (ss_rise) fv_now = (cnt_q == 6'd32);
      fv_d = fv_now;
      if (latch_fall && fv_now) begin
        fv_d = 1'b0;
        if (f_cmd == CMD_WRITE) mem_we = f_in_range;
        else if (f_cmd == CMD_READ) tx_d = {rd_hdr, f_word};
      end
    end
  end

  // Shifter, counter and frame-valid state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_q  <= '0;
      tx_q  <= '0;
      cnt_q <= '0;
      fv_q  <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      cnt_q <= cnt_d;
      fv_q  <= fv_d;
    end
  end

  // Register memory; write port from committed frames
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[f_idx] <= f_data;
    end
  end

  // Actuator read port: one cycle latency, old data on a same-cycle write
  always_ff @(posedge clock) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
  end

endmodule

// File: tb/tb_spi_latched_regfile.sv
// Bench for spi_latched_regfile: an SPI host drives frames and latch pulses,
// a reference model predicts miso frames and rd_data, and monitors compare.
`timescale 1ns/1ps

module tb_spi_latched_regfile;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_n = 1'b0;
  logic        latch_data_n = 1'b1;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, miso_oeb;
  logic [7:0]  rd_addr = 8'h00;
  logic [15:0] rd_data;

  always #5 clock = ~clock;

  spi_latched_regfile dut (
    .clock(clock), .reset_n(reset_n), .enable_n(enable_n),
    .latch_data_n(latch_data_n), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oeb(miso_oeb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic        oeb;
  } frame_exp_t;

  frame_exp_t  frame_q[$];
  logic [15:0] rd_q[$];
  logic        rd_chk = 1'b0;

  // Reference model state
  logic [15:0] mem_m [16];
  logic [31:0] tx_m = 32'h0;
  logic [31:0] rx_m = 32'h0;
  logic        fv_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hdr_of(input logic [7:0] a);
`ifdef SPI_ECHO_HEADER_EN
    return {8'h01, a};
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    return (a < 8'd16) ? mem_m[a[3:0]] : 16'h0000;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One SPI frame of nbits, mode 0, sclk period 12 system clocks
  task automatic spi_xfer(input logic [31:0] word, input int nbits);
    frame_exp_t e;
    e.data  = (nbits >= 32) ? tx_m : (tx_m >> (32 - nbits));
    e.nbits = nbits;
    e.oeb   = enable_n;
    frame_q.push_back(e);
    @(negedge clock);
    ss_n = 1'b0;
    clks(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[31-i];
      clks(6);
      sclk = 1'b1;
      clks(6);
      sclk = 1'b0;
    end
    clks(6);
    ss_n = 1'b1;
    mosi = 1'b0;
    clks(8);
    if (!enable_n) begin
      tx_m = (nbits >= 32) ? 32'h0 : (tx_m << nbits);
      fv_m = (nbits == 32);
      rx_m = word;
    end
  endtask

  task automatic latch_pulse();
    @(negedge clock);
    latch_data_n = 1'b0;
    clks(4);
    latch_data_n = 1'b1;
    clks(6);
    if (!enable_n && fv_m) begin
      fv_m = 1'b0;
      if (rx_m[31:24] == 8'h02) begin
        if (rx_m[23:16] < 8'd16) mem_m[rx_m[19:16]] = rx_m[15:0];
      end else if (rx_m[31:24] == 8'h01) begin
        tx_m = {hdr_of(rx_m[23:16]), mem_rd(rx_m[23:16])};
      end
    end
  endtask

  task automatic set_enable_n(input logic v);
    @(negedge clock);
    enable_n = v;
    if (v) begin
      tx_m = 32'h0;
      fv_m = 1'b0;
    end
    clks(2);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    spi_xfer({8'h02, a, d}, 32);
    latch_pulse();
  endtask

  // read frame, latch, then a zero frame that carries the response
  task automatic read_word(input logic [7:0] a);
    spi_xfer({8'h01, a, 16'h0000}, 32);
    latch_pulse();
    spi_xfer(32'h0, 32);
  endtask

  task automatic rd_probe(input logic [7:0] a);
    @(negedge clock);
    rd_addr = a;
    rd_q.push_back(mem_rd(a));
    rd_chk = 1'b1;
    @(negedge clock);
    rd_chk = 1'b0;
  endtask

  // Frame monitor: collect miso on host sclk rises, compare at ss_n rise
  initial begin
    forever begin
      logic [31:0] cap;
      int          n;
      logic        oeb_and, oeb_or;
      frame_exp_t  e;
      @(negedge ss_n);
      cap = 32'h0; n = 0; oeb_and = 1'b1; oeb_or = 1'b0;
      forever begin
        @(posedge sclk or posedge ss_n);
        if (ss_n) break;
        cap = {cap[30:0], miso};
        n++;
        oeb_and &= miso_oeb;
        oeb_or  |= miso_oeb;
      end
      if (frame_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL frame_queue: actual empty required an expected frame");
      end else begin
        e = frame_q.pop_front();
        check("miso_frame", cap, e.data);
        check("frame_bits", n, e.nbits);
        check("miso_oeb_in_frame", {30'h0, oeb_or, oeb_and}, {30'h0, e.oeb, e.oeb});
      end
      repeat (4) @(negedge clock);
      check("idle_oeb_miso", {30'h0, miso_oeb, miso}, 32'h2);
    end
  end

  // Read-port monitor: rd_data one cycle after rd_addr is applied
  initial begin
    forever begin
      @(posedge clock);
      if (rd_chk) begin
        #1;
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_queue: actual empty required an expected word");
        end else begin
          check("rd_data", {16'h0, rd_data}, {16'h0, rd_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] pd [10];
    pd = '{16'hFACE, 16'hDEAD, 16'hBEEF, 16'hAAAA, 16'h5555,
           16'hAA55, 16'h55AA, 16'hDADE, 16'hFFFF, 16'hDAED};
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;

    clks(5);
    check("reset_rd_data", {16'h0, rd_data}, 32'h0);
    check("reset_miso_oeb", {31'h0, miso_oeb}, 32'h1);
    check("reset_miso", {31'h0, miso}, 32'h0);
    reset_n = 1'b1;
    clks(4);

    read_word(8'h00);

    for (int i = 0; i < 10; i++) begin
      write_word(8'(i), pd[i]);
      read_word(8'(i));
    end

    // aborted write frame
    spi_xfer({8'h02, 8'h00, 16'h1111}, 20);
    latch_pulse();
    read_word(8'h00);

    // double latch on one frame, then an unknown command
    spi_xfer(32'h0203_1234, 32);
    latch_pulse();
    latch_pulse();
    read_word(8'h03);
    spi_xfer(32'h0705_9999, 32);
    latch_pulse();
    read_word(8'h05);

    // disabled block ignores SPI and latch
    set_enable_n(1'b1);
    spi_xfer(32'h0206_0000, 32);
    latch_pulse();
    set_enable_n(1'b0);
    read_word(8'h06);

    // out-of-range address and read port
    write_word(8'h3C, 16'h0020);
    read_word(8'h3C);
    rd_probe(8'h3C);
    rd_probe(8'h02);
    rd_probe(8'h09);

    for (int it = 0; it < 30; it++) begin
      int          r;
      logic [7:0]  a;
      logic [15:0] d;
      r = int'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 19));
      d = 16'($urandom);
      case (r)
        0, 1, 2, 3: write_word(a, d);
        4, 5:       read_word(a);
        6: begin
          spi_xfer({8'($urandom_range(0, 3)), a, d}, 32);
          repeat ($urandom_range(0, 2)) latch_pulse();
        end
        7: begin
          spi_xfer({8'h02, a, d}, int'($urandom_range(1, 31)));
          latch_pulse();
        end
        8: begin
          set_enable_n(1'b1);
          spi_xfer({8'h02, a, d}, 32);
          latch_pulse();
          set_enable_n(1'b0);
        end
        default: rd_probe(a);
      endcase
    end

    for (int i = 0; i < 16; i++) rd_probe(8'(i));
    spi_xfer(32'h0, 32);

    clks(20);
    check("frame_queue_drained", frame_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_latched_regfile.md
Name: spi_latched_regfile

Overview:
- SPI-slave-accessed 16-bit register memory inside the actuator-controller user project, driven from mprj_io pins.
- An external host shifts a 32-bit command frame {cmd[7:0], addr[7:0], data[15:0]} over SPI.
- An active-low latch strobe commits the frame, either writing the memory or staging read data.
- Staged read data is returned on the next SPI frame.
- A second, synchronous read port feeds the downstream actuator drivers.

Parameters:
- DEPTH, 16, number of 16-bit words; valid addresses 0..DEPTH-1.
- DATA_W, 16, word width; fixed at 16 by the frame format.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- enable_n  in  1  active-low block enable; when high, SPI and latch are ignored.
- latch_data_n  in  1  active-low commit strobe, asynchronous to clock.
- ss_n  in  1  SPI slave select, active low.
- sclk  in  1  SPI clock; idles low, mode 0.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- miso_oeb  out  1  pad output-enable for miso, active low.
- rd_addr  in  8  actuator-side read address.
- rd_data  out  16  actuator-side read data.

Behaviour:
- Synchronizers: ss_n, sclk, mosi and latch_data_n each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals. Requirement: clock ≥ 8× sclk.
- Receive:
  - On each synchronized sclk rise with ss_n low, shift mosi into a 32-bit rx register, MSB first, and increment a 6-bit bit counter.
  - ss_n fall clears the counter.
  - ss_n rise with counter == 32 sets frame_valid and holds rx. Any other count discards the frame (frame_valid = 0).
- Transmit:
  - On ss_n fall, the tx register is presented and miso = tx[31].
  - Each synchronized sclk fall shifts tx left and drives the next bit.
  - The first bit is stable before the first sclk rise.
  - miso_oeb = 0 only while ss_n low and enable_n low; otherwise miso_oeb = 1 and miso = 0.
- Commit on a synchronized latch_data_n falling edge, only when frame_valid = 1 and enable_n = 0:
  - cmd 0x02: mem[addr] <= data.
  - cmd 0x01: tx <= response word (see Optional Feature), low 16 bits = mem[addr].
  - Any other cmd: no action.
  - frame_valid is cleared after every commit attempt, so a single frame commits at most once.
- Address range: addr ≥ DEPTH causes writes to be dropped and reads to return 16'h0000.
- tx persistence: tx is not reloaded after shifting. A following frame without a new read commit shifts out zeros, because vacated bits fill with 0.
- Same-cycle events: a latch edge in the same cycle as an ss_n rise uses the frame completed in that cycle, i.e. frame_valid setting takes priority before commit evaluation.
- rd_data: registered, 1-cycle latency, mem[rd_addr]; 0 when out of range. A same-cycle write to the same address returns the old value.
- enable_n high: rx, counter, frame_valid and tx are held at their reset values; memory contents are retained.
- Reset values: mem all 0x0000, rx 0, tx 0, counter 0, frame_valid 0, miso 0, miso_oeb 1, rd_data 0. Reset asserted mid-frame aborts the frame; the host must restart with a fresh ss_n cycle.

Optional Feature:
- SPI_ECHO_HEADER_EN
- Defined: a read commit loads tx = {8'h01, addr, mem[addr]}, echoing the header for host framing checks.
- Undefined: tx = {16'h0000, mem[addr]}.
- The low 16 bits are identical in both builds.

Test Plan:
- Reset, then read address 0 → low 16 bits of the returned frame = 0x0000; miso_oeb = 1 while ss_n high.
- Write then read back pairs (0x00, FACE), (0x01, DEAD), (0x02, BEEF), (0x03, AAAA), (0x04, 5555), (0x05, AA55), (0x06, 55AA), (0x07, DADE), (0x08, FFFF), (0x09, DAED): each sequence is frame, latch pulse, read frame, latch pulse, zero frame → low 16 bits of the read-back equal the written data. With SPI_ECHO_HEADER_EN, the upper 16 bits = {01, addr}.
- Abort a write frame after 20 bits, then pulse latch → memory unchanged; a read of that address returns the prior value.
- Write frame 0x0203_1234 sent, latch pulsed twice → single write, no side effects. Command 0x07 → no memory change.
- enable_n = 1 during a write frame plus latch → memory unchanged and miso_oeb stays 1.
- Write 0x20 to address 0x3C (DEPTH = 16) → dropped; a read returns 0x0000. rd_addr = 0x02 after writing BEEF → rd_data = 0xBEEF one cycle later.
